rv32_mod_fetch_aligner: RTL and testbench

- Sits directly upstream of the rv32 instruction decoder. Converts the stream of 32-bit-aligned fetch words from the instruction memory port into one instruction per handshake.
- Each instruction is either 16-bit compressed or 32-bit, at any halfword-aligned PC, including 32-bit instructions that straddle two fetch words.
- Handles PC redirects (branch/jump/trap) by flushing and realigning.

---
 rtl/rv32_mod_fetch_aligner.sv | 117 +++++++++++
 tb/tb_rv32_mod_fetch_aligner.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/rv32_mod_fetch_aligner.sv
// Fetch aligner: turns a stream of 32-bit fetch words into one RV32/RVC
// instruction per handshake, handling halfword-aligned and straddling fetches.
module rv32_mod_fetch_aligner #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] fetch_data,
    input  logic        fetch_valid,
    output logic        fetch_ready,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic [31:0] inst,
    output logic [31:0] inst_pc,
    output logic        inst_compressed,
    output logic        inst_valid,
    input  logic        inst_ready
);

    logic [15:0] hw_q [3];
    logic [15:0] hw_d [3];
    logic [15:0] sh   [3];
    logic [1:0]  count_q, count_d;
    logic [31:0] pc_q, pc_d;
    logic        skip_low_q, skip_low_d;

    logic        compressed;
    logic        valid_int;
    logic [1:0]  consumed;
    logic [1:0]  remaining;
    logic [1:0]  appended;
    logic        accept;

    // Output decode and handshake, all from registered state.
    always_comb begin
        compressed      = (hw_q[0][1:0] != 2'b11);
        valid_int       = !redirect && (((count_q >= 2'd1) && compressed) || (count_q >= 2'd2));
        inst            = (valid_int && compressed) ? {16'h0000, hw_q[0]} : {hw_q[1], hw_q[0]};
        inst_pc         = pc_q;
        inst_valid      = valid_int;
        inst_compressed = valid_int && compressed;
        consumed        = (valid_int && inst_ready) ? (compressed ? 2'd1 : 2'd2) : 2'd0;
        remaining       = count_q - consumed;
        fetch_ready     = !redirect && (remaining <= 2'd1);
        accept          = fetch_valid && fetch_ready;
    end

    // Shift out consumed halfwords, then append the accepted fetch word behind the leftovers.
    always_comb begin
        for (int i = 0; i < 3; i++) begin
            sh[i] = hw_q[i];
        end
        case (consumed)
            2'd1: begin
                sh[0] = hw_q[1];
                sh[1] = hw_q[2];
            end
            2'd2: sh[0] = hw_q[2];
            default: ;
        endcase

        for (int i = 0; i < 3; i++) begin
            hw_d[i] = sh[i];
        end
        appended   = 2'd0;
        skip_low_d = skip_low_q;

        if (accept) begin
            if (skip_low_q) begin
                if (remaining == 2'd0) hw_d[0] = fetch_data[31:16];
                else                   hw_d[1] = fetch_data[31:16];
                appended   = 2'd1;
                skip_low_d = 1'b0;
            end else begin
                if (remaining == 2'd0) begin
                    hw_d[0] = fetch_data[15:0];
                    hw_d[1] = fetch_data[31:16];
                end else begin
                    hw_d[1] = fetch_data[15:0];
                    hw_d[2] = fetch_data[31:16];
                end
                appended = 2'd2;
            end
        end

        count_d = remaining + appended;
        pc_d    = pc_q + {29'd0, consumed, 1'b0};

        if (redirect) begin
            for (int i = 0; i < 3; i++) begin
                hw_d[i] = hw_q[i];
            end
            count_d    = 2'd0;
            pc_d       = {redirect_pc[31:1], 1'b0};
            skip_low_d = redirect_pc[1];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 3; i++) begin
                hw_q[i] <= 16'h0000;
            end
            count_q    <= 2'd0;
            pc_q       <= {RESET_PC[31:1], 1'b0};
            skip_low_q <= RESET_PC[1];
        end else begin
            for (int i = 0; i < 3; i++) begin
                hw_q[i] <= hw_d[i];
            end
            count_q    <= count_d;
            pc_q       <= pc_d;
            skip_low_q <= skip_low_d;
        end
    end

endmodule

// File: tb/tb_rv32_mod_fetch_aligner.sv
// Scoreboard bench for rv32_mod_fetch_aligner: directed fetch words in,
// expected instructions queued, monitor compares on every inst handshake.
module tb_rv32_mod_fetch_aligner;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] fetch_data = 32'h0;
    logic        fetch_valid = 1'b0;
    logic        fetch_ready;
    logic        redirect = 1'b0;
    logic [31:0] redirect_pc = 32'h0;
    logic [31:0] inst;
    logic [31:0] inst_pc;
    logic        inst_compressed;
    logic        inst_valid;
    logic        inst_ready = 1'b1;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct packed {
        logic [31:0] inst;
        logic [31:0] pc;
        logic        c;
    } exp_t;

    exp_t exp_q[$];

    rv32_mod_fetch_aligner #(.RESET_PC(32'h0000_0000)) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .fetch_data      (fetch_data),
        .fetch_valid     (fetch_valid),
        .fetch_ready     (fetch_ready),
        .redirect        (redirect),
        .redirect_pc     (redirect_pc),
        .inst            (inst),
        .inst_pc         (inst_pc),
        .inst_compressed (inst_compressed),
        .inst_valid      (inst_valid),
        .inst_ready      (inst_ready)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic expect_inst(input logic [31:0] i, input logic [31:0] pc, input logic c);
        exp_t e;
        e.inst = i;
        e.pc   = pc;
        e.c    = c;
        exp_q.push_back(e);
    endtask

    // Monitor: every accepted instruction must match the head of the scoreboard.
    always @(negedge clk) begin
        if (rst_n && inst_valid && inst_ready) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_inst: got %h at pc %h expected nothing", inst, inst_pc);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                check("inst", inst, e.inst);
                check("inst_pc", inst_pc, e.pc);
                check("inst_compressed", {31'd0, inst_compressed}, {31'd0, e.c});
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_word(input logic [31:0] w, output int stalls);
        bit done;
        stalls = 0;
        done = 0;
        fetch_data  = w;
        fetch_valid = 1'b1;
        for (int i = 0; i < 40 && !done; i++) begin
            @(negedge clk);
            if (fetch_ready) done = 1;
            else stalls++;
            tick();
        end
        if (!done) begin
            n_checks++;
            n_fail++;
            $display("FAIL push_timeout: word %h never accepted, expected acceptance", w);
        end
        fetch_valid = 1'b0;
    endtask

    task automatic do_redirect(input logic [31:0] pc);
        redirect    = 1'b1;
        redirect_pc = pc;
        @(negedge clk);
        check("redir_inst_valid", {31'd0, inst_valid}, 32'd0);
        check("redir_fetch_ready", {31'd0, fetch_ready}, 32'd0);
        tick();
        redirect = 1'b0;
    endtask

    task automatic wait_empty(input string name);
        for (int i = 0; i < 60 && exp_q.size() != 0; i++) tick();
        check(name, exp_q.size(), 32'd0);
    endtask

    initial begin
        int st;
        int st_sum;

        #2;
        check("rst_inst_valid", {31'd0, inst_valid}, 32'd0);
        check("rst_fetch_ready", {31'd0, fetch_ready}, 32'd1);
        check("rst_inst", inst, 32'd0);
        check("rst_inst_pc", inst_pc, 32'd0);
        check("rst_inst_compressed", {31'd0, inst_compressed}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();

        // Back-to-back aligned 32-bit instructions at full throughput.
        expect_inst(32'h00A00093, 32'h0, 1'b0);
        expect_inst(32'h00100113, 32'h4, 1'b0);
        push_word(32'h00A00093, st);
        st_sum = st;
        push_word(32'h00100113, st);
        st_sum += st;
        check("t1_fetch_stalls", st_sum, 32'd0);
        wait_empty("t1_drain");

        // Compressed stream; the zero upper half of word 2 decodes as compressed too.
        do_redirect(32'h0);
        expect_inst(32'h00000085, 32'h0, 1'b1);
        expect_inst(32'h00004505, 32'h2, 1'b1);
        expect_inst(32'h00004585, 32'h4, 1'b1);
        expect_inst(32'h00000000, 32'h6, 1'b1);
        push_word(32'h4505_0085, st);
        push_word(32'h0000_4585, st);
        wait_empty("t2_drain");

        // Straddling 32-bit instruction.
        do_redirect(32'h0);
        expect_inst(32'h00004505, 32'h0, 1'b1);
        expect_inst(32'h00A00093, 32'h2, 1'b0);
        expect_inst(32'h00004585, 32'h6, 1'b1);
        push_word(32'h0093_4505, st);
        repeat (3) tick();
        @(negedge clk);
        check("t3_straddle_held", {31'd0, inst_valid}, 32'd0);
        check("t3_pending", exp_q.size(), 32'd2);
        tick();
        push_word(32'h4585_00A0, st);
        wait_empty("t3_drain");

        // Fill to 3 halfwords, then redirect to 0x102 and realign.
        inst_ready = 1'b0;
        do_redirect(32'h2);
        push_word(32'h0001_AAAA, st);
        push_word(32'h0002_0003, st);
        @(negedge clk);
        check("t4_full_fetch_ready", {31'd0, fetch_ready}, 32'd0);
        check("t4_full_inst_valid", {31'd0, inst_valid}, 32'd1);
        tick();
        do_redirect(32'h0000_0102);
        inst_ready = 1'b1;
        expect_inst(32'h00A00093, 32'h102, 1'b0);
        expect_inst(32'h00004585, 32'h106, 1'b1);
        push_word(32'h0093_5678, st);
        repeat (2) tick();
        @(negedge clk);
        check("t4_wait_high_half", {31'd0, inst_valid}, 32'd0);
        check("t4_pc", inst_pc, 32'h102);
        tick();
        push_word(32'h4585_00A0, st);
        wait_empty("t4_drain");

        // Backpressure: decoder stalls 5 cycles while fetch keeps offering.
        do_redirect(32'h0);
        inst_ready = 1'b0;
        expect_inst(32'h00A00093, 32'h0, 1'b0);
        expect_inst(32'h00100113, 32'h4, 1'b0);
        expect_inst(32'h00004505, 32'h8, 1'b1);
        expect_inst(32'h00004585, 32'hA, 1'b1);
        fork
            begin
                push_word(32'h00A00093, st);
                push_word(32'h00100113, st);
                push_word(32'h4585_4505, st);
            end
            begin
                repeat (3) @(posedge clk);
                for (int k = 0; k < 5; k++) begin
                    @(negedge clk);
                    check("t5_stall_inst", inst, 32'h00A00093);
                    check("t5_stall_pc", inst_pc, 32'h0);
                    check("t5_stall_valid", {31'd0, inst_valid}, 32'd1);
                    check("t5_stall_fetch_ready", {31'd0, fetch_ready}, 32'd0);
                end
                tick();
                inst_ready = 1'b1;
            end
        join
        wait_empty("t5_drain");

        // PC wrap past 0xFFFF_FFFE.
        do_redirect(32'hFFFF_FFFE);
        expect_inst(32'h00004505, 32'hFFFF_FFFE, 1'b1);
        expect_inst(32'h00004585, 32'h0, 1'b1);
        expect_inst(32'h00000000, 32'h2, 1'b1);
        push_word(32'h4505_1111, st);
        push_word(32'h0000_4585, st);
        wait_empty("t6_drain");

        // Async reset with a full queue.
        inst_ready = 1'b0;
        do_redirect(32'h2);
        push_word(32'h0001_AAAA, st);
        push_word(32'h0002_0003, st);
        #2;
        rst_n = 1'b0;
        #1;
        check("t7_rst_inst_valid", {31'd0, inst_valid}, 32'd0);
        check("t7_rst_fetch_ready", {31'd0, fetch_ready}, 32'd1);
        check("t7_rst_pc", inst_pc, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        check("t7_post_rst_valid", {31'd0, inst_valid}, 32'd0);
        check("t7_post_rst_pc", inst_pc, 32'h0);
        inst_ready = 1'b1;
        expect_inst(32'h00A00093, 32'h0, 1'b0);
        push_word(32'h00A00093, st);
        wait_empty("t7_drain");

        repeat (3) tick();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

endmodule
